// File: rtl/fpm_exp.sv
// -----------------------------------------------------------------------------
// fpm_exp -- exponent and normalisation sequencer for the floating-point path.
//
// Takes two signed exponents and an operation, then steps the fraction unit
// through alignment shifts, the fraction-operation handshake and normalisation
// shifts while tracking the result exponent. Produces the final exponent and
// sticky range flags.
//
// Parameters
//   EW  exponent width (signed two's complement)
//   FW  fraction width; limit for alignment and normalisation shifts
//   CW  shift counter width
//
// Ports
//   __clk    rising-edge clock
//   _0_f     asynchronous active-high reset
//   start    one-cycle request, accepted only in IDLE
//   op       00 AF, 01 SF, 10 MF, 11 DF (sampled with start)
//   ea, eb   signed operand exponents (sampled with start)
//   fr_done  fraction unit finished its operation
//   fr_zero  fraction result is zero (valid in NORM)
//   norm_l   fraction needs a left shift by one (valid in NORM)
//   norm_r   fraction needs a right shift by one (valid in NORM)
//   busy     high from the cycle after start through DONE
//   swp      AF/SF: operand A is the smaller one
//   shr_a    alignment right-shift of fraction A this cycle
//   shr_b    alignment right-shift of fraction B this cycle
//   fr_go    one-cycle pulse starting the fraction operation
//   norm_en  high while normalising
//   done     one-cycle completion pulse
//   exp_r    result exponent
//   g        smaller operand lost in alignment
//   ovf      result exponent overflowed (exp_r wrapped)
//   unf      result exponent underflowed (exp_r forced to 0)
//   zero     result is zero
// -----------------------------------------------------------------------------
module fpm_exp #(
    parameter int EW = 8,
    parameter int FW = 40,
    parameter int CW = $clog2(FW + 1)
) (
    input  logic          __clk,
    input  logic          _0_f,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] eb,
    input  logic          fr_done,
    input  logic          fr_zero,
    input  logic          norm_l,
    input  logic          norm_r,
    output logic          busy,
    output logic          swp,
    output logic          shr_a,
    output logic          shr_b,
    output logic          fr_go,
    output logic          norm_en,
    output logic          done,
    output logic [EW-1:0] exp_r,
    output logic          g,
    output logic          ovf,
    output logic          unf,
    output logic          zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ARITH,
        S_NORM,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_AF = 2'b00,
        OP_SF = 2'b01,
        OP_MF = 2'b10,
        OP_DF = 2'b11
    } op_t;

    // Representable range of the EW-bit result, held at the width of X.
    localparam logic signed [EW+1:0] X_MAX = (EW+2)'(2**(EW-1) - 1);
    localparam logic signed [EW+1:0] X_MIN = (EW+2)'(-(2**(EW-1)));

    state_t                 state_q, state_d;
    logic signed [EW+1:0]   x_q, x_d;
    logic [CW-1:0]          k_q, k_d;

    logic                   busy_q, busy_d;
    logic                   swp_q, swp_d;
    logic                   shr_a_q, shr_a_d;
    logic                   shr_b_q, shr_b_d;
    logic                   fr_go_q, fr_go_d;
    logic                   norm_en_q, norm_en_d;
    logic                   done_q, done_d;
    logic [EW-1:0]          exp_r_q, exp_r_d;
    logic                   g_q, g_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   zero_q, zero_d;

    logic signed [EW+1:0]   ea_x, eb_x, diff;
    logic [EW+1:0]          abs_diff;
    logic                   big_diff;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        x_d      = x_q;
        k_d      = k_q;
        swp_d    = swp_q;
        g_d      = g_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        zero_d   = zero_q;
        exp_r_d  = exp_r_q;

        ea_x     = {{2{ea[EW-1]}}, ea};
        eb_x     = {{2{eb[EW-1]}}, eb};
        diff     = ea_x - eb_x;
        abs_diff = diff[EW+1] ? -diff : diff;
        big_diff = int'(abs_diff) >= FW;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    swp_d   = 1'b0;
                    g_d     = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    exp_r_d = '0;
                    k_d     = '0;
                    case (op_t'(op))
                        OP_AF, OP_SF: begin
                            swp_d = diff[EW+1];
                            x_d   = diff[EW+1] ? eb_x : ea_x;
                            // An exponent gap of FW or more shifts the smaller
                            // fraction out completely, so alignment is skipped.
                            if (big_diff) begin
                                g_d     = 1'b1;
                                state_d = S_ARITH;
                            end else begin
                                k_d     = CW'(abs_diff);
                                state_d = S_ALIGN;
                            end
                        end
                        OP_MF: begin
                            x_d     = ea_x + eb_x;
                            state_d = S_ARITH;
                        end
                        default: begin
                            x_d     = ea_x - eb_x;
                            state_d = S_ARITH;
                        end
                    endcase
                end
            end

            S_ALIGN: begin
                // The last shift and the exit share a cycle, so fr_go follows
                // the final shift directly; K = 0 still costs one cycle.
                if (k_q != '0) begin
                    k_d = k_q - CW'(1);
                end
                if (k_q <= CW'(1)) begin
                    state_d = S_ARITH;
                end
            end

            S_ARITH: begin
                if (fr_done) begin
                    k_d     = '0;
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                if (fr_zero) begin
                    zero_d  = 1'b1;
                    x_d     = '0;
                    state_d = S_DONE;
                end else if (norm_r) begin
                    x_d = x_q + (EW+2)'(1);
                end else if (norm_l) begin
                    // More than FW left shifts means the fraction held no
                    // significant bits at all.
                    if (int'(k_q) + 1 > FW) begin
                        zero_d  = 1'b1;
                        x_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        x_d = x_q - (EW+2)'(1);
                        k_d = k_q + CW'(1);
                    end
                end else begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Range evaluation happens on the way into DONE so exp_r and the
        // flags are already valid in the cycle done is high.
        if (state_d == S_DONE) begin
            if (x_d > X_MAX) begin
                ovf_d   = 1'b1;
                exp_r_d = x_d[EW-1:0];
            end else if (x_d < X_MIN) begin
                unf_d   = 1'b1;
                zero_d  = 1'b1;
                exp_r_d = '0;
            end else begin
                exp_r_d = x_d[EW-1:0];
            end
        end

        // Strobes are decoded from the next state so they leave the flops
        // aligned with the state they belong to.
        busy_d    = (state_d != S_IDLE);
        shr_a_d   = (state_d == S_ALIGN) && (k_d != '0) && swp_d;
        shr_b_d   = (state_d == S_ALIGN) && (k_d != '0) && !swp_d;
        fr_go_d   = (state_d == S_ARITH) && (state_q != S_ARITH);
        norm_en_d = (state_d == S_NORM);
        done_d    = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge __clk or posedge _0_f) begin
        if (_0_f) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            swp_q     <= 1'b0;
            shr_a_q   <= 1'b0;
            shr_b_q   <= 1'b0;
            fr_go_q   <= 1'b0;
            norm_en_q <= 1'b0;
            done_q    <= 1'b0;
            exp_r_q   <= '0;
            g_q       <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            k_q       <= k_d;
            busy_q    <= busy_d;
            swp_q     <= swp_d;
            shr_a_q   <= shr_a_d;
            shr_b_q   <= shr_b_d;
            fr_go_q   <= fr_go_d;
            norm_en_q <= norm_en_d;
            done_q    <= done_d;
            exp_r_q   <= exp_r_d;
            g_q       <= g_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            zero_q    <= zero_d;
        end
    end

    assign busy    = busy_q;
    assign swp     = swp_q;
    assign shr_a   = shr_a_q;
    assign shr_b   = shr_b_q;
    assign fr_go   = fr_go_q;
    assign norm_en = norm_en_q;
    assign done    = done_q;
    assign exp_r   = exp_r_q;
    assign g       = g_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_fpm_exp.sv
// -----------------------------------------------------------------------------
// tb_fpm_exp -- scoreboard bench for fpm_exp (EW = 8, FW = 32).
//
// Each directed vector carries its hand-computed result. Issuing a vector
// pushes it onto the expected queue; a monitor counts alignment shifts and the
// fr_go cycle per transaction and compares against the queue head on done.
// A small fraction-unit model answers fr_go and drives the norm requests.
// -----------------------------------------------------------------------------
module tb_fpm_exp;

    localparam int EW = 8;
    localparam int FW = 32;

    localparam logic [1:0] AF = 2'b00;
    localparam logic [1:0] SF = 2'b01;
    localparam logic [1:0] MF = 2'b10;
    localparam logic [1:0] DF = 2'b11;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [EW-1:0] ea, eb;
    logic          fr_done, fr_zero, norm_l, norm_r;
    logic          busy, swp, shr_a, shr_b, fr_go, norm_en, done;
    logic [EW-1:0] exp_r;
    logic          g, ovf, unf, zero;

    int n_checks = 0;
    int n_fail   = 0;

    fpm_exp #(.EW(EW), .FW(FW)) dut (
        .__clk   (clk),
        ._0_f    (rst),
        .start   (start),
        .op      (op),
        .ea      (ea),
        .eb      (eb),
        .fr_done (fr_done),
        .fr_zero (fr_zero),
        .norm_l  (norm_l),
        .norm_r  (norm_r),
        .busy    (busy),
        .swp     (swp),
        .shr_a   (shr_a),
        .shr_b   (shr_b),
        .fr_go   (fr_go),
        .norm_en (norm_en),
        .done    (done),
        .exp_r   (exp_r),
        .g       (g),
        .ovf     (ovf),
        .unf     (unf),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // flags field order: {swp, g, ovf, unf, zero}
    typedef struct {
        string         name;
        logic [1:0]    op;
        logic [EW-1:0] ea;
        logic [EW-1:0] eb;
        int            dly;     // cycles from fr_go to fr_done
        int            n_r;     // NORM cycles with norm_r
        int            n_l;     // NORM cycles with norm_l (after the norm_r ones)
        int            n_both;  // NORM cycles with norm_l and norm_r together
        bit            fz;      // fr_zero throughout NORM
        logic [EW-1:0] exp_r;
        logic [4:0]    flags;
        int            sa;      // expected shr_a pulses
        int            sb;      // expected shr_b pulses
        int            go;      // expected fr_go cycle (1 = first busy cycle)
        bit            poke;    // extra start while busy
        bit            ondone;  // extra start coincident with done
    } vec_t;

    vec_t cur;
    vec_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, swp, shr_a, shr_b, fr_go, norm_en, done, g, ovf, unf, zero, exp_r});
    endfunction

    function automatic vec_t mk(input string name, input logic [1:0] o, input int a, input int b,
                                input int dly, input int n_r, input int n_l, input int n_both,
                                input bit fz, input logic [EW-1:0] er, input logic [4:0] fl,
                                input int sa, input int sb, input int go,
                                input bit poke, input bit ondone);
        vec_t v;
        v.name = name; v.op = o; v.ea = EW'(a); v.eb = EW'(b);
        v.dly = dly; v.n_r = n_r; v.n_l = n_l; v.n_both = n_both; v.fz = fz;
        v.exp_r = er; v.flags = fl; v.sa = sa; v.sb = sb; v.go = go;
        v.poke = poke; v.ondone = ondone;
        return v;
    endfunction

    // Fraction-unit model.
    int go_cnt   = -1;
    int norm_idx = 0;
    always @(negedge clk) begin
        if (rst) begin
            fr_done = 1'b0; fr_zero = 1'b0; norm_l = 1'b0; norm_r = 1'b0;
            go_cnt = -1; norm_idx = 0;
        end else begin
            if (fr_go) go_cnt = cur.dly;
            fr_done = (go_cnt == 0);
            if (go_cnt >= 0) go_cnt--;
            if (norm_en) begin
                fr_zero = cur.fz;
                norm_r  = (norm_idx < cur.n_r) || (norm_idx < cur.n_both);
                norm_l  = (norm_idx >= cur.n_r && norm_idx < cur.n_r + cur.n_l) ||
                          (norm_idx < cur.n_both);
                norm_idx++;
            end else begin
                fr_zero = 1'b0; norm_l = 1'b0; norm_r = 1'b0; norm_idx = 0;
            end
        end
    end

    // Monitor: per-transaction shift/fr_go tracking, compare on done.
    bit   in_txn     = 0;
    bit   after_done = 0;
    int   cyc, na, nb, go_cyc;
    vec_t e;
    always @(negedge clk) begin
        if (rst) begin
            in_txn = 0; after_done = 0;
        end else begin
            if (after_done) begin
                check("done_one_cycle_busy_low", 32'({done, busy}), 0);
                after_done = 0;
            end
            if (busy && !in_txn) begin
                in_txn = 1; cyc = 1; na = 0; nb = 0; go_cyc = -1;
            end else if (in_txn) begin
                cyc++;
            end
            if (in_txn) begin
                if (shr_a) na++;
                if (shr_b) nb++;
                if (fr_go) begin
                    if (go_cyc < 0) go_cyc = cyc;
                    else check("fr_go_single_pulse", 32'(cyc), 32'(go_cyc));
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, ".exp_r"}, 32'(exp_r), 32'(e.exp_r));
                        check({e.name, ".flags"}, 32'({swp, g, ovf, unf, zero}), 32'(e.flags));
                        check({e.name, ".shr_a_count"}, 32'(na), 32'(e.sa));
                        check({e.name, ".shr_b_count"}, 32'(nb), 32'(e.sb));
                        check({e.name, ".fr_go_cycle"}, 32'(go_cyc), 32'(e.go));
                    end
                    in_txn = 0;
                    after_done = 1;
                end
            end
        end
    end

    // Issue one vector; called and returning at a negedge with the DUT idle.
    task automatic run(input vec_t v);
        int t;
        cur = v;
        exp_q.push_back(v);
        start = 1'b1; op = v.op; ea = v.ea; eb = v.eb;
        @(negedge clk);
        start = 1'b0;
        if (v.poke) begin
            @(negedge clk);
            start = 1'b1; op = DF; ea = 8'd7; eb = 8'd1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({v.name, ".done_seen"}, 32'(done), 1);
        if (!done) begin
            exp_q.delete();
            rst = 1'b1;
            @(negedge clk); @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end else if (v.ondone) begin
            start = 1'b1; op = MF; ea = 8'd1; eb = 8'd1;
            @(negedge clk);
            start = 1'b0;
            check({v.name, ".start_on_done_ignored"}, 32'(busy), 0);
        end else begin
            @(negedge clk);
        end
    endtask

    int n_done;

    initial begin
        rst = 1'b1; start = 1'b0; op = AF; ea = '0; eb = '0;
        cur = mk("none", AF, 0, 0, 0, 0, 0, 0, 0, 8'h00, 5'b00000, 0, 0, 0, 0, 0);

        //             name          op  ea    eb  dly nr  nl  nb  fz  exp_r  flags     sa  sb  go  pk od
        vecs.push_back(mk("af_5_2",    AF,    5,   2, 2,  0,  0,  0,  0, 8'h05, 5'b00000, 0,  3,  4,  1, 0));
        vecs.push_back(mk("sf_big",    SF,   -3,  40, 1,  0,  0,  0,  0, 8'h28, 5'b11000, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_ovf",    MF,  100,  50, 0,  0,  0,  0,  0, 8'h96, 5'b00100, 0,  0,  1,  0, 0));
        vecs.push_back(mk("df_unf",    DF, -100,  50, 0,  0,  0,  0,  0, 8'h00, 5'b00011, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_nl2",    MF,    3,   4, 1,  0,  2,  0,  0, 8'h05, 5'b00000, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_nr1",    MF,    3,   4, 1,  1,  0,  0,  0, 8'h08, 5'b00000, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_both",   MF,    3,   4, 1,  0,  0,  2,  0, 8'h09, 5'b00000, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_fz",     MF,    3,   4, 1,  0,  0,  0,  1, 8'h00, 5'b00001, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_nl_lim", MF,    3,   4, 0,  0, 33,  0,  0, 8'h00, 5'b00001, 0,  0,  1,  0, 0));
        vecs.push_back(mk("af_d0",     AF,    0,   0, 0,  0,  0,  0,  0, 8'h00, 5'b00000, 0,  0,  2,  0, 0));
        vecs.push_back(mk("af_d31",    AF,   31,   0, 1,  0,  0,  0,  0, 8'h1F, 5'b00000, 0, 31, 32,  0, 0));
        vecs.push_back(mk("af_d32",    AF,    0,  32, 1,  0,  0,  0,  0, 8'h20, 5'b11000, 0,  0,  1,  0, 0));
        vecs.push_back(mk("sf_swp",    SF,   -2,   1, 1,  0,  0,  0,  0, 8'h01, 5'b10000, 3,  0,  4,  0, 0));
        vecs.push_back(mk("mf_127",    MF,  100,  27, 0,  0,  0,  0,  0, 8'h7F, 5'b00000, 0,  0,  1,  0, 0));
        vecs.push_back(mk("mf_128",    MF,  100,  27, 0,  1,  0,  0,  0, 8'h80, 5'b00100, 0,  0,  1,  0, 0));
        vecs.push_back(mk("df_m128",   DF, -100,  28, 0,  0,  0,  0,  0, 8'h80, 5'b00000, 0,  0,  1,  0, 1));
        vecs.push_back(mk("df_m129",   DF, -100,  28, 0,  0,  1,  0,  0, 8'h00, 5'b00011, 0,  0,  1,  0, 0));

        @(negedge clk);
        @(negedge clk);
        check("reset_state", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run(vecs[i]);

        // Reset in cycle 2 of an AF with a 10-shift alignment.
        cur = mk("abort", AF, 10, 0, 0, 0, 0, 0, 0, 8'h00, 5'b00000, 0, 10, 11, 0, 0);
        start = 1'b1; op = AF; ea = 8'd10; eb = 8'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.outputs_cleared", all_outs(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort.no_done", 32'(n_done), 0);

        run(mk("af_after_rst", AF, 5, 2, 2, 0, 0, 0, 0, 8'h05, 5'b00000, 0, 3, 4, 0, 0));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpm_exp.md
# fpm_exp

Parametrised exponent and normalisation sequencer for the floating-point path. It takes two signed exponents and an operation (add, subtract, multiply, divide), then drives the fraction unit through three phases: alignment shifts, the fraction-operation handshake and normalisation shifts. It tracks the result exponent throughout and produces the final exponent with range flags. It generalises the fixed 8-bit exponent logic and FIC shift counter of the F-PM unit to any exponent and fraction width, adding multi-step normalisation and explicit underflow handling.

## Interface
Parameters:
- EW, 8, exponent width (signed two's complement).
- FW, 40, fraction width; it is the alignment and normalisation shift limit.
- CW, $clog2(FW+1), shift counter width.

Ports:
- __clk  in  1  clock, rising edge.
- _0_f  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; ignored while busy.
- op  in  2  00 AF, 01 SF, 10 MF, 11 DF; sampled with start.
- ea, eb  in  EW  operand exponents, signed; sampled with start.
- fr_done  in  1  fraction unit has finished its operation.
- fr_zero  in  1  fraction result is zero; valid in NORM.
- norm_l  in  1  fraction needs a left shift by 1; valid in NORM.
- norm_r  in  1  fraction overflowed and needs a right shift by 1; valid in NORM.
- busy  out  1  high from the cycle after start until DONE, inclusive.
- swp  out  1  AF/SF only: eb > ea, so operand A is the smaller one. Held from ALIGN until the next start.
- shr_a, shr_b  out  1  one alignment right-shift of fraction A or B this cycle.
- fr_go  out  1  one-cycle pulse that starts the fraction operation.
- norm_en  out  1  high in NORM; the fraction unit shifts on the same edge as its norm_l/norm_r request.
- done  out  1  one-cycle pulse; the outputs below are valid from this cycle and held until the next start.
- exp_r  out  EW  result exponent.
- g, ovf, unf, zero  out  1 each  sticky flags, defined under Operation.

## Operation
- Internal exponent register X is signed, EW+2 bits. Shift counter K is CW bits.
- Reset forces state IDLE and clears every output, X and K. Reset asserted mid-operation aborts the operation with no done pulse.
- IDLE, start: latch ea, eb and op; clear all flags.
  - AF/SF: D = ea − eb (EW+2 bits); swp = (D < 0); X = max(ea, eb); K = |D|; go to ALIGN.
  - MF: X = ea + eb; go to ARITH.
  - DF: X = ea − eb; go to ARITH.
- ALIGN:
  - If |D| ≥ FW: set g; issue no shifts; go to ARITH. The smaller operand is treated as lost.
  - Else, while K ≠ 0: assert shr_a if swp, otherwise shr_b; decrement K.
  - When K = 0, go to ARITH. With D = 0, ALIGN lasts 1 cycle with no shift.
- ARITH: fr_go is pulsed in the first cycle; the block waits for fr_done (which may arrive in the first cycle) and then goes to NORM. K is cleared.
- NORM, evaluated once per cycle, in this priority order:
  1. fr_zero: set zero, X = 0, go to DONE.
  2. norm_r: X = X + 1.
  3. norm_l: X = X − 1 and K = K + 1. If K would exceed FW, set zero, X = 0 and go to DONE.
  4. Otherwise go to DONE.
- DONE (1 cycle, done pulse):
  - X > 2^(EW−1)−1: set ovf; exp_r = X[EW−1:0] (wrapped).
  - X < −2^(EW−1): set unf and zero; exp_r = 0.
  - Otherwise exp_r = X[EW−1:0].
  - Go to IDLE.
- Flags are sticky until the next accepted start.

## Timing
- start sampled at edge 0. The first ALIGN or ARITH cycle is cycle 1.
- AF/SF with shift count n (0 < n < FW): shifts occur in cycles 1..n; fr_go in cycle n+1 (cycle 2 when n = 0).
- MF/DF: fr_go in cycle 1.
- NORM begins the cycle after fr_done is sampled. Each shift costs 1 cycle, and the terminating evaluation costs 1 cycle.
- done rises the cycle after NORM exits and is high for exactly 1 cycle. busy falls together with done.
- A start coincident with done is ignored. A new start is accepted from the cycle after done.

## Test plan
- AF, ea=5, eb=2, fr_done 2 cycles after fr_go, no norm requests -> shr_b in cycles 1–3, fr_go in cycle 4, swp=0, exp_r=5, all flags 0.
- SF, ea=−3, eb=40, FW=32 -> swp=1, g=1, no shr_a/shr_b, fr_go in cycle 1, exp_r=40.
- MF, ea=100, eb=50, EW=8 -> ovf=1, exp_r=8'h96. DF, ea=−100, eb=50 -> unf=1, zero=1, exp_r=0.
- MF, ea=3, eb=4; norm_l for 2 cycles then idle -> exp_r=5. Repeat with a single norm_r -> exp_r=8. Hold norm_l and norm_r together -> norm_r wins.
- fr_zero in the first NORM cycle -> zero=1, exp_r=0. Hold norm_l for FW+1 cycles -> zero=1, exp_r=0.
- Assert _0_f in cycle 2 of an AF with ea=10, eb=0 -> all outputs 0 immediately, no done. The next start is accepted normally.
